// File: rtl/laser500_pkg.sv
// Shared types and defaults for the Laser500 memory mapper: FSM states, I/O defaults, log2 helper.
package laser500_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_IOACC = 2'd3
  } map_state_t;

  localparam logic [7:0] IO_BASE_DEF = 8'h40;
  localparam int         IO_PAGE_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/laser500_bankreg.sv
// Bank register file with I/O port decode: one write per OUT cycle, combinational IN readback.
// Latency: OUT lands two clocks after the raw strobes fall; no backpressure (the CPU bus never stalls here).
module laser500_bankreg
  import laser500_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter int         PAGE_BITS = 4,
  parameter logic [7:0] IO_BASE   = IO_BASE_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_iorq_n,
  input  logic                           i_rd_n,
  input  logic                           i_wr_n,
  input  logic                           i_m1_n,
  input  logic [7:0]                     i_port,
  input  logic [PAGE_BITS-1:0]           i_dat,
  output logic                           o_rd_vld,
  output logic [7:0]                     o_rd_dat,
  output logic [NUM_SLOTS*PAGE_BITS-1:0] o_bank_q
);

  localparam int SLOT_W = clog2(NUM_SLOTS);

  logic [PAGE_BITS-1:0] r_bank [NUM_SLOTS];
  logic                 r_io_wr_d;
  logic [7:0]           w_ofs;
  logic [SLOT_W-1:0]    w_idx;
  logic                 w_hit;
  logic                 w_io_wr;

  assign w_ofs   = i_port - IO_BASE;
  assign w_hit   = (w_ofs < 8'(NUM_SLOTS));
  assign w_idx   = w_ofs[SLOT_W-1:0];
  assign w_io_wr = !i_iorq_n && !i_wr_n && i_m1_n && w_hit;

  // Rising edge of the decoded write so a long OUT cycle updates the register once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_io_wr_d <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_bank[i] <= PAGE_BITS'(i);
    end else begin
      r_io_wr_d <= w_io_wr;
      if (w_io_wr && !r_io_wr_d) r_bank[w_idx] <= i_dat;
    end
  end

  assign o_rd_vld = !i_iorq_n && !i_rd_n && i_m1_n && w_hit;
  assign o_rd_dat = 8'(r_bank[w_idx]);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign o_bank_q[g*PAGE_BITS +: PAGE_BITS] = r_bank[g];
  end

endmodule

// File: rtl/laser500_mapper.sv
// CPU->SDRAM bank mapper with WAIT_n and download muxing; sd_req one clock after start, data one clock after sd_ack.
// CPU is stalled via cpu_wait_n while sd_req waits for sd_ack; LASER500_MAPPER_ROMPROT_EN blocks CPU ROM writes.
module laser500_mapper
  import laser500_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter int         PAGE_BITS = 4,
  parameter int         PHYS_AW   = 25,
  parameter logic [7:0] IO_BASE   = IO_BASE_DEF,
  parameter int         IO_PAGE   = IO_PAGE_DEF,
  parameter int         ROM_PAGES = 4
) (
  input  logic                           F14M,
  input  logic                           RESET_n,
  input  logic [15:0]                    cpu_addr,
  input  logic [7:0]                     cpu_dout,
  input  logic                           cpu_mreq_n,
  input  logic                           cpu_iorq_n,
  input  logic                           cpu_rd_n,
  input  logic                           cpu_wr_n,
  input  logic                           cpu_m1_n,
  output logic [7:0]                     cpu_din,
  output logic                           cpu_wait_n,
  input  logic                           dl_active,
  input  logic [PHYS_AW-1:0]             dl_addr,
  input  logic [7:0]                     dl_data,
  input  logic                           dl_wr,
  output logic                           sd_req,
  output logic                           sd_we,
  output logic [PHYS_AW-1:0]             sd_addr,
  output logic [7:0]                     sd_din,
  input  logic                           sd_ack,
  input  logic [7:0]                     sd_dout,
  output logic                           io_sel,
  input  logic [7:0]                     io_din,
  output logic [NUM_SLOTS*PAGE_BITS-1:0] bank_q
);

  localparam int SLOT_W = clog2(NUM_SLOTS);
  localparam int OFS_W  = 16 - SLOT_W;
`ifdef LASER500_MAPPER_ROMPROT_EN
  localparam bit ROMPROT = 1'b1;
`else
  localparam bit ROMPROT = 1'b0;
`endif

  map_state_t           r_state, w_state_nxt;
  logic                 r_mreq_n, r_iorq_n, r_rd_n, r_wr_n, r_m1_n;
  logic                 r_armed, r_is_dl;
  logic                 r_sd_we;
  logic [PHYS_AW-1:0]   r_sd_addr, r_dl_addr;
  logic [7:0]           r_sd_din, r_cpu_din, r_dl_data;
  logic                 r_dl_full;
  logic [PAGE_BITS-1:0] w_bank [NUM_SLOTS];
  logic [SLOT_W-1:0]    w_slot;
  logic [PAGE_BITS-1:0] w_page;
  logic [PHYS_AW-1:0]   w_phys;
  logic                 w_cpu_start, w_rom_blk, w_cpu_take, w_go_cpu, w_go_dl;
  logic                 w_io_rd_vld;
  logic [7:0]           w_io_rd_dat;

  laser500_bankreg #(
    .NUM_SLOTS (NUM_SLOTS),
    .PAGE_BITS (PAGE_BITS),
    .IO_BASE   (IO_BASE)
  ) u_bankreg (
    .i_clk    (F14M),
    .i_rst_n  (RESET_n),
    .i_iorq_n (r_iorq_n),
    .i_rd_n   (r_rd_n),
    .i_wr_n   (r_wr_n),
    .i_m1_n   (r_m1_n),
    .i_port   (cpu_addr[7:0]),
    .i_dat    (cpu_dout[PAGE_BITS-1:0]),
    .o_rd_vld (w_io_rd_vld),
    .o_rd_dat (w_io_rd_dat),
    .o_bank_q (bank_q)
  );

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_bank
    assign w_bank[g] = bank_q[g*PAGE_BITS +: PAGE_BITS];
  end

  assign w_slot = cpu_addr[15 -: SLOT_W];
  assign w_page = w_bank[w_slot];
  assign w_phys = PHYS_AW'({w_page, cpu_addr[OFS_W-1:0]});

  // Armed while mreq is high, so a late wr_n still starts exactly one access per memory cycle.
  assign w_cpu_start = r_armed && !r_mreq_n && (!r_rd_n || !r_wr_n) && !dl_active;
  assign w_rom_blk   = ROMPROT && !r_wr_n && (int'(w_page) < ROM_PAGES);

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cpu_take  = 1'b0;
    w_go_cpu    = 1'b0;
    w_go_dl     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_dl_full) begin
          w_state_nxt = ST_REQ;
          w_go_dl     = 1'b1;
        end else if (w_cpu_start) begin
          w_cpu_take = 1'b1;
          if (w_page == PAGE_BITS'(IO_PAGE)) begin
            w_state_nxt = ST_IOACC;
          end else if (w_rom_blk) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_REQ;
            w_go_cpu    = 1'b1;
          end
        end
      end
      ST_REQ:   if (sd_ack) w_state_nxt = r_is_dl ? ST_IDLE : ST_HOLD;
      ST_HOLD,
      ST_IOACC: if (r_mreq_n) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_mreq_n  <= 1'b1;
      r_iorq_n  <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_m1_n    <= 1'b1;
      r_armed   <= 1'b0;
      r_is_dl   <= 1'b0;
      r_sd_we   <= 1'b0;
      r_sd_addr <= '0;
      r_sd_din  <= '0;
      r_cpu_din <= 8'hFF;
      r_dl_full <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
    end else begin
      r_mreq_n <= cpu_mreq_n;
      r_iorq_n <= cpu_iorq_n;
      r_rd_n   <= cpu_rd_n;
      r_wr_n   <= cpu_wr_n;
      r_m1_n   <= cpu_m1_n;
      if (r_mreq_n)        r_armed <= 1'b1;
      else if (w_cpu_take) r_armed <= 1'b0;
      if (w_go_cpu) begin
        r_is_dl   <= 1'b0;
        r_sd_we   <= !r_wr_n;
        r_sd_addr <= w_phys;
        r_sd_din  <= cpu_dout;
      end else if (w_go_dl) begin
        r_is_dl   <= 1'b1;
        r_sd_we   <= 1'b1;
        r_sd_addr <= r_dl_addr;
        r_sd_din  <= r_dl_data;
      end
      if (r_state == ST_REQ && sd_ack && !r_is_dl && !r_sd_we) r_cpu_din <= sd_dout;
      // The buffer slot frees as its write issues, so a back-to-back dl_wr is still taken.
      if (w_go_dl) r_dl_full <= 1'b0;
      if (dl_wr && (!r_dl_full || w_go_dl)) begin
        r_dl_full <= 1'b1;
        r_dl_addr <= dl_addr;
        r_dl_data <= dl_data;
      end
    end
  end

  assign sd_req     = (r_state == ST_REQ);
  assign sd_we      = r_sd_we;
  assign sd_addr    = r_sd_addr;
  assign sd_din     = r_sd_din;
  assign io_sel     = (r_state == ST_IOACC);
  assign cpu_wait_n = !(w_go_cpu || (r_state == ST_REQ && !r_is_dl));

  always_comb begin
    cpu_din = r_cpu_din;
    if (r_state == ST_IOACC) cpu_din = io_din;
    else if (w_io_rd_vld)    cpu_din = w_io_rd_dat;
  end

endmodule

// File: tb/tb_laser500_mapper.sv
// Directed self-checking bench for laser500_mapper (default parameters).
module tb_laser500_mapper;

  logic        F14M = 1'b0;
  logic        RESET_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic        dl_active;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        sd_req, sd_we;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        io_sel;
  logic [7:0]  io_din;
  logic [15:0] bank_q;

  int checks   = 0;
  int failures = 0;

  always #5 F14M = ~F14M;

  laser500_mapper dut (
    .F14M       (F14M),
    .RESET_n    (RESET_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_m1_n   (cpu_m1_n),
    .cpu_din    (cpu_din),
    .cpu_wait_n (cpu_wait_n),
    .dl_active  (dl_active),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wr      (dl_wr),
    .sd_req     (sd_req),
    .sd_we      (sd_we),
    .sd_addr    (sd_addr),
    .sd_din     (sd_din),
    .sd_ack     (sd_ack),
    .sd_dout    (sd_dout),
    .io_sel     (io_sel),
    .io_din     (io_din),
    .bank_q     (bank_q)
  );

  task automatic tick();
    @(posedge F14M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && sd_req !== 1'b1; i++) tick();
    chk(tag, 32'(sd_req), 32'h1);
  endtask

  initial begin
    RESET_n = 1'b0;
    cpu_addr = '0; cpu_dout = '0;
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
    dl_active = 1'b0; dl_addr = '0; dl_data = '0; dl_wr = 1'b0;
    sd_ack = 1'b0; sd_dout = '0; io_din = '0;
    tick(); tick();
    RESET_n = 1'b1;
    tick();

    chk("rst_bank_q",  32'(bank_q),     32'h3210);
    chk("rst_wait_n",  32'(cpu_wait_n), 32'h1);
    chk("rst_cpu_din", 32'(cpu_din),    32'hFF);
    chk("rst_sd_req",  32'(sd_req),     32'h0);
    chk("rst_io_sel",  32'(io_sel),     32'h0);
    chk("rst_sd_addr", 32'(sd_addr),    32'h0);

    // OUT (41h),07h held several clocks
    cpu_addr = 16'h0741; cpu_dout = 8'h07; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    tick(); tick(); tick();
    cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
    chk("out41_bank_q", 32'(bank_q), 32'h3270);

    cpu_addr = 16'h0950; cpu_dout = 8'h0F; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    tick(); tick();
    cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
    chk("out50_ignored", 32'(bank_q), 32'h3270);

    cpu_addr = 16'h0041; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    tick();
    chk("in41_din", 32'(cpu_din), 32'h07);
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    tick();
    chk("in41_release_din", 32'(cpu_din), 32'hFF);

    // Read 4123h through bank[1]=7
    cpu_addr = 16'h4123; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    tick();
    chk("rd_detect_wait_n", 32'(cpu_wait_n), 32'h0);
    chk("rd_detect_no_req", 32'(sd_req),     32'h0);
    tick();
    chk("rd_req",      32'(sd_req),     32'h1);
    chk("rd_addr",     32'(sd_addr),    32'h1C123);
    chk("rd_we",       32'(sd_we),      32'h0);
    chk("rd_wait_low", 32'(cpu_wait_n), 32'h0);
    chk("rd_din_old",  32'(cpu_din),    32'hFF);
    tick(); tick();
    chk("rd_req_held", 32'(sd_req), 32'h1);
    sd_dout = 8'h5A; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0; sd_dout = 8'h00;
    chk("rd_ack_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("rd_ack_din",    32'(cpu_din),    32'h5A);
    chk("rd_ack_req",    32'(sd_req),     32'h0);
    tick();
    chk("rd_hold_din", 32'(cpu_din), 32'h5A);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();

    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("stray_ack_req",    32'(sd_req),     32'h0);
    chk("stray_ack_wait_n", 32'(cpu_wait_n), 32'h1);

    // Write A5h to 8000h: slot 2 maps to the I/O page
    cpu_addr = 16'h8000; cpu_dout = 8'hA5; io_din = 8'h3E; cpu_mreq_n = 1'b0;
    tick();
    cpu_wr_n = 1'b0;
    tick();
    chk("io_detect_wait_n", 32'(cpu_wait_n), 32'h1);
    tick();
    chk("io_sel",    32'(io_sel),     32'h1);
    chk("io_no_req", 32'(sd_req),     32'h0);
    chk("io_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("io_din",    32'(cpu_din),    32'h3E);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    tick(); tick();
    chk("io_sel_end", 32'(io_sel), 32'h0);

    // Write 77h to 0000h (ROM page 0), wr_n one clock after mreq_n
    cpu_addr = 16'h0000; cpu_dout = 8'h77; cpu_mreq_n = 1'b0;
    tick();
    chk("wr_t1_wait_n", 32'(cpu_wait_n), 32'h1);
    cpu_wr_n = 1'b0;
    tick();
`ifdef LASER500_MAPPER_ROMPROT_EN
    chk("rom_wait_n", 32'(cpu_wait_n), 32'h1);
    tick();
    chk("rom_no_req", 32'(sd_req),     32'h0);
    chk("rom_wait_2", 32'(cpu_wait_n), 32'h1);
`else
    chk("wr_wait_n", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("wr_req",  32'(sd_req),  32'h1);
    chk("wr_we",   32'(sd_we),   32'h1);
    chk("wr_addr", 32'(sd_addr), 32'h0);
    chk("wr_din",  32'(sd_din),  32'h77);
`endif

    // Asynchronous reset with the access outstanding
    #2 RESET_n = 1'b0;
    #1;
    chk("arst_req",    32'(sd_req),     32'h0);
    chk("arst_wait_n", 32'(cpu_wait_n), 32'h1);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
    RESET_n = 1'b1; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("late_ack_req",     32'(sd_req),     32'h0);
    chk("late_ack_wait_n",  32'(cpu_wait_n), 32'h1);
    chk("arst_bank_q",      32'(bank_q),     32'h3210);
    chk("arst_cpu_din",     32'(cpu_din),    32'hFF);
    tick();

    // Download write arriving while a CPU read of C000h is in REQ
    cpu_addr = 16'hC000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    tick(); tick();
    chk("dlcpu_req",  32'(sd_req),  32'h1);
    chk("dlcpu_addr", 32'(sd_addr), 32'hC000);
    dl_active = 1'b1; dl_addr = 25'h10; dl_data = 8'h3C; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk("dlcpu_addr_frozen", 32'(sd_addr), 32'hC000);
    chk("dlcpu_we",          32'(sd_we),   32'h0);
    sd_dout = 8'h11; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("dlcpu_din",    32'(cpu_din),    32'h11);
    chk("dlcpu_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("dlcpu_idle",   32'(sd_req),     32'h0);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    wait_req("dl_req", 10);
    chk("dl_we",   32'(sd_we),   32'h1);
    chk("dl_addr", 32'(sd_addr), 32'h10);
    chk("dl_din",  32'(sd_din),  32'h3C);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("dl_done_req", 32'(sd_req), 32'h0);
    dl_active = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
